// File: rtl/guess_sequencer.sv
// Game-flow controller for the 3-digit guessing game: buffers keypad digits,
// latches the secret, issues entries to the overlay at frame start, and scores guesses.
module guess_sequencer #(
  parameter int MAX_GUESS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       key_enter,
  input  logic       key_clear,
  input  logic       frame_start,
  output logic [3:0] oNum1,
  output logic [3:0] oNum2,
  output logic [3:0] oNum3,
  output logic       oNumRdy,
  output logic [1:0] digit_cnt,
  output logic [3:0] guess_cnt,
  output logic [2:0] game_state,
  output logic       win,
  output logic       lose,
  output logic       err
);

  typedef enum logic [2:0] {
    S_SECRET = 3'd0,
    S_SPEND  = 3'd1,
    S_GUESS  = 3'd2,
    S_GPEND  = 3'd3,
    S_CHECK  = 3'd4,
    S_WIN    = 3'd5,
    S_LOSE   = 3'd6
  } state_t;

  state_t state, state_d;

  // slot_p0: keypad buffer; pend_p1: accepted entry awaiting a frame start
  logic [2:0][3:0] slot_p0;
  logic [2:0][3:0] pend_p1;
  logic [2:0][3:0] secret;

  logic buf_clr, buf_store, accept, issue, err_d;

  function automatic logic all_distinct(input logic [2:0][3:0] s);
    return (s[0] != s[1]) && (s[0] != s[2]) && (s[1] != s[2]);
  endfunction

  function automatic logic [1:0] match_count(input logic [2:0][3:0] g,
                                             input logic [2:0][3:0] r);
    logic [1:0] n;
    n = '0;
    for (int i = 0; i < 3; i++)
      if (g[i] == r[i]) n = n + 2'd1;
    return n;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_SECRET;
    else        state <= state_d;
  end

  // Next-state and per-cycle action decode; key priority clear > enter > valid
  always_comb begin
    state_d   = state;
    buf_clr   = 1'b0;
    buf_store = 1'b0;
    accept    = 1'b0;
    issue     = 1'b0;
    err_d     = 1'b0;
    case (state)
      S_SECRET, S_GUESS: begin
        if (key_clear) begin
          buf_clr = 1'b1;
        end else if (key_enter) begin
          if (digit_cnt == 2'd3 && all_distinct(slot_p0)) begin
            accept  = 1'b1;
            state_d = (state == S_SECRET) ? S_SPEND : S_GPEND;
          end else begin
            err_d = 1'b1;
          end
        end else if (key_valid) begin
          if (key_digit <= 4'd9 && digit_cnt != 2'd3) buf_store = 1'b1;
          else                                        err_d     = 1'b1;
        end
      end
      S_SPEND: begin
        if (frame_start) begin
          issue   = 1'b1;
          state_d = S_GUESS;
        end
      end
      S_GPEND: begin
        if (frame_start) begin
          issue   = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (match_count(pend_p1, secret) == 2'd3) state_d = S_WIN;
        else if (guess_cnt == 4'(MAX_GUESS))      state_d = S_LOSE;
        else                                      state_d = S_GUESS;
      end
      S_WIN, S_LOSE: state_d = state;
      default:       state_d = S_SECRET;
    endcase
  end

  // Datapath and registered outputs; everything clears so a reset drops pending data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_p0   <= '0;
      pend_p1   <= '0;
      secret    <= '0;
      digit_cnt <= '0;
      guess_cnt <= '0;
      oNum1     <= '0;
      oNum2     <= '0;
      oNum3     <= '0;
      oNumRdy   <= 1'b0;
      err       <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;
    end else begin
      oNumRdy <= issue;
      err     <= err_d;
      win     <= (state_d == S_WIN);
      lose    <= (state_d == S_LOSE);
      if (buf_clr || accept) begin
        digit_cnt <= '0;
      end else if (buf_store) begin
        for (int i = 0; i < 3; i++)
          if (digit_cnt == 2'(i)) slot_p0[i] <= key_digit;
        digit_cnt <= digit_cnt + 2'd1;
      end
      if (accept) pend_p1 <= slot_p0;
      if (issue) begin
        oNum1 <= pend_p1[0];
        oNum2 <= pend_p1[1];
        oNum3 <= pend_p1[2];
      end
      if (issue && state == S_SPEND) secret <= pend_p1;
      if (issue && state == S_GPEND && guess_cnt != 4'd15)
        guess_cnt <= guess_cnt + 4'd1;
    end
  end

  assign game_state = state;

endmodule
